// File: rtl/sevseg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan capture block.
package sevseg_pkg;

    // Default timing parameters
    localparam int SETTLE_DEF = 16;
    localparam int FRAMES_DEF = 2;

    // Active-low segment patterns, seg[0]=a .. seg[6]=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble codes and binary marker
    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_BAD     = 4'hE;
    localparam logic [6:0] BIN_INVALID = 7'h7F;

    // Digit slot indices (an bit positions)
    localparam logic [1:0] DIG_IDX_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_IDX_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_IDX_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_IDX_MIN_TENS = 2'd3;

    // Classification of the registered digit-enable lines
    typedef enum logic [1:0] {
        AN_IDLE  = 2'd0,
        AN_VALID = 2'd1,
        AN_FAULT = 2'd2
    } an_class_e;

    // Idle when no digit is enabled, fault when more than one is
    function automatic an_class_e an_classify(input logic [3:0] an_v);
        an_class_e cls;
        case (an_v)
            4'b1111: cls = AN_IDLE;
            4'b1110: cls = AN_VALID;
            4'b1101: cls = AN_VALID;
            4'b1011: cls = AN_VALID;
            4'b0111: cls = AN_VALID;
            default: cls = AN_FAULT;
        endcase
        return cls;
    endfunction

    // Slot index of a single active-low enable; only meaningful for AN_VALID
    function automatic logic [1:0] an_index(input logic [3:0] an_v);
        logic [1:0] idx;
        case (an_v)
            4'b1110: idx = DIG_IDX_SEC_ONES;
            4'b1101: idx = DIG_IDX_SEC_TENS;
            4'b1011: idx = DIG_IDX_MIN_ONES;
            4'b0111: idx = DIG_IDX_MIN_TENS;
            default: idx = DIG_IDX_SEC_ONES;
        endcase
        return idx;
    endfunction

    // Two BCD nibbles to binary; non-decimal nibbles yield the invalid marker
    function automatic logic [6:0] pair_to_bin(input logic [3:0] hi, input logic [3:0] lo);
        logic [6:0] val;
        if ((hi <= 4'd9) && (lo <= 4'd9)) begin
            val = ({3'b000, hi} * 7'd10) + {3'b000, lo};
        end else begin
            val = BIN_INVALID;
        end
        return val;
    endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Combinational active-low seven-segment pattern to digit nibble decoder.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       illegal_o
);

    // Map each known pattern to its nibble; anything else is flagged illegal
    always_comb begin
        nibble_o  = DIG_BAD;
        illegal_o = 1'b0;
        case (pattern_i)
            SEG_0:     nibble_o = 4'd0;
            SEG_1:     nibble_o = 4'd1;
            SEG_2:     nibble_o = 4'd2;
            SEG_3:     nibble_o = 4'd3;
            SEG_4:     nibble_o = 4'd4;
            SEG_5:     nibble_o = 4'd5;
            SEG_6:     nibble_o = 4'd6;
            SEG_7:     nibble_o = 4'd7;
            SEG_8:     nibble_o = 4'd8;
            SEG_9:     nibble_o = 4'd9;
            SEG_BLANK: nibble_o = DIG_BLANK;
            default: begin
                nibble_o  = DIG_BAD;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevseg_capture.sv
// Passive monitor of a 4-digit multiplexed seven-segment scan; rebuilds and
// publishes MM:SS once consecutive complete frames agree.
module sevseg_capture
    import sevseg_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int FRAMES = FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [6:0]  min,
    output logic [6:0]  sec,
    output logic        upd,
    output logic        err
);

    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int FCNT_W = $clog2(FRAMES + 1);

    // Input sample and the sample from the cycle before
    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic [6:0]  seg_p_q;
    logic [3:0]  an_p_q;

    // Dwell tracking
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    an_class_e         an_cls_s;
    logic              same_s;
    logic              capture_s;
    logic [1:0]        cap_idx_s;
    logic [3:0]        dec_nib_s;
    logic              dec_bad_s;

    // Frame assembly
    logic [15:0]       buf_q, buf_d;
    logic [3:0]        mask_q, mask_d;
    logic [15:0]       prev_q, prev_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Published outputs
    logic [15:0] digits_q, digits_d;
    logic [6:0]  min_q, min_d;
    logic [6:0]  sec_q, sec_d;
    logic        upd_q, upd_d;
    logic        err_q, err_d;
    logic        publish_s;

    // Decoder sees the dwelling sample, which is the one the counter refers to
    sevseg_decode u_decode (
        .pattern_i (seg_p_q),
        .nibble_o  (dec_nib_s),
        .illegal_o (dec_bad_s)
    );

    // Register raw bus and keep one cycle of history for the stability compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1111;
            seg_p_q <= SEG_BLANK;
            an_p_q  <= 4'b1111;
        end else begin
            seg_q   <= seg;
            an_q    <= an;
            seg_p_q <= seg_q;
            an_p_q  <= an_q;
        end
    end

    assign an_cls_s  = an_classify(an_q);
    assign same_s    = (an_q == an_p_q) && (seg_q == seg_p_q);
    assign cap_idx_s = an_index(an_p_q);
    // Counter holds SETTLE-1 for exactly one cycle per dwell because it keeps counting to SETTLE
    assign capture_s = (an_cls_s == AN_VALID) && (dwell_q == CNT_W'(SETTLE - 1));

    // Dwell counter: counts identical valid samples, saturating one above the capture point
    always_comb begin
        dwell_d = {CNT_W{1'b0}};
        if (an_cls_s != AN_VALID) begin
            dwell_d = {CNT_W{1'b0}};
        end else if (!same_s) begin
            dwell_d = {CNT_W{1'b0}};
        end else if (dwell_q == CNT_W'(SETTLE)) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    // Capture into the frame buffer and compare each completed frame with the last one
    always_comb begin
        buf_d  = buf_q;
        mask_d = mask_q;
        prev_d = prev_q;
        fcnt_d = fcnt_q;
        if (capture_s) begin
            buf_d[{cap_idx_s, 2'b00} +: 4] = dec_nib_s;
            mask_d[cap_idx_s]              = 1'b1;
        end else begin
            buf_d  = buf_q;
            mask_d = mask_q;
        end
        if (capture_s && (mask_d == 4'b1111)) begin
            mask_d = 4'b0000;
            if (buf_d == prev_q) begin
                if (fcnt_q == FCNT_W'(FRAMES)) begin
                    fcnt_d = fcnt_q;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end else begin
                prev_d = buf_d;
                fcnt_d = FCNT_W'(1);
            end
        end else begin
            prev_d = prev_q;
            fcnt_d = fcnt_q;
        end
    end

    // Publish a stable frame only when it differs from what is already shown
    assign publish_s = (fcnt_q == FCNT_W'(FRAMES)) && (prev_q != digits_q);

    // Output next-state: load digits and binary values together with the update pulse
    always_comb begin
        digits_d = digits_q;
        min_d    = min_q;
        sec_d    = sec_q;
        upd_d    = 1'b0;
        if (publish_s) begin
            digits_d = prev_q;
            min_d    = pair_to_bin(prev_q[15:12], prev_q[11:8]);
            sec_d    = pair_to_bin(prev_q[7:4], prev_q[3:0]);
            upd_d    = 1'b1;
        end else begin
            upd_d    = 1'b0;
        end
    end

    // Sticky error: bus fault on the enables or an unknown pattern captured
    always_comb begin
        err_d = err_q;
        if ((an_cls_s == AN_FAULT) || (capture_s && dec_bad_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Dwell, frame and publish state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q  <= {CNT_W{1'b0}};
            buf_q    <= 16'hFFFF;
            mask_q   <= 4'b0000;
            prev_q   <= 16'hFFFF;
            fcnt_q   <= {FCNT_W{1'b0}};
            digits_q <= 16'hFFFF;
            min_q    <= BIN_INVALID;
            sec_q    <= BIN_INVALID;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dwell_q  <= dwell_d;
            buf_q    <= buf_d;
            mask_q   <= mask_d;
            prev_q   <= prev_d;
            fcnt_q   <= fcnt_d;
            digits_q <= digits_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign digits = digits_q;
    assign min    = min_q;
    assign sec    = sec_q;
    assign upd    = upd_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sevseg_capture.sv
// Randomized self-checking bench for sevseg_capture with a segment-level reference model.
module tb_sevseg_capture;

    localparam int SETTLE = 16;
    localparam int FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [6:0]  min;
    logic [6:0]  sec;
    logic        upd;
    logic        err;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;

    // Reference model state: what a correct monitor should hold
    logic [3:0] m_buf  [4];
    logic [3:0] m_prev [4];
    logic [3:0] m_dig  [4];
    bit   [3:0] m_mask;
    int         m_cnt;
    bit         m_err;
    int         m_upd = 0;

    sevseg_capture #(.SETTLE(SETTLE), .FRAMES(FRAMES)) dut (
        .clk    (clk),
        .reset  (reset),
        .seg    (seg),
        .an     (an),
        .digits (digits),
        .min    (min),
        .sec    (sec),
        .upd    (upd),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Count update pulses, one per high cycle
    always @(negedge clk) begin
        if (upd === 1'b1) upd_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Display pattern for a digit value; 14 stands for a deliberately illegal pattern
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d >= 0 && d <= 9) return tbl[d];
        if (d == 14) return 7'h55;
        return 7'h7F;
    endfunction

    function automatic logic [3:0] m_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (seg_of(i) == p) return 4'(i);
        end
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [6:0] m_bin(input logic [3:0] hi, input logic [3:0] lo);
        if (hi < 4'd10 && lo < 4'd10) return 7'(int'(hi) * 10 + int'(lo));
        return 7'h7F;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_buf[i]  = 4'hF;
            m_prev[i] = 4'hF;
            m_dig[i]  = 4'hF;
        end
        m_mask = 4'b0000;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic m_capture(input int idx, input logic [3:0] nib);
        bit same;
        bit diff_pub;
        if (nib == 4'hE) m_err = 1'b1;
        m_buf[idx]  = nib;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'b1111) begin
            same = 1'b1;
            for (int i = 0; i < 4; i++) if (m_buf[i] != m_prev[i]) same = 1'b0;
            if (same) begin
                if (m_cnt < FRAMES) m_cnt++;
            end else begin
                for (int i = 0; i < 4; i++) m_prev[i] = m_buf[i];
                m_cnt = 1;
            end
            m_mask = 4'b0000;
            diff_pub = 1'b0;
            for (int i = 0; i < 4; i++) if (m_prev[i] != m_dig[i]) diff_pub = 1'b1;
            if (m_cnt == FRAMES && diff_pub) begin
                for (int i = 0; i < 4; i++) m_dig[i] = m_prev[i];
                m_upd++;
            end
        end
    endtask

    // A held bus value of len cycles: captured if it outlasts the settle window
    task automatic m_segment(input logic [3:0] a, input logic [6:0] s, input int len);
        int zeros;
        int idx;
        zeros = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros >= 2) m_err = 1'b1;
        else if (zeros == 1 && len >= SETTLE + 1) m_capture(idx, m_decode(s));
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int len);
        m_segment(a, s, len);
        an  = a;
        seg = s;
        repeat (len) @(negedge clk);
    endtask

    // One scan pass d3..d0; dwell 0 picks a random dwell per digit
    task automatic scan_frame(input logic [15:0] val, input int dwell, input int gap, input bit ghost);
        int dw;
        for (int k = 3; k >= 0; k--) begin
            dw = dwell;
            if (dwell == 0) begin
                dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 15))
                                                 : int'($urandom_range(17, 40));
            end
            if (ghost && k == 0) drive(4'b1110, seg_of(1), 3);
            drive(~(4'b0001 << k), seg_of(int'(val[k*4 +: 4])), dw);
            if (gap > 0) drive(4'b1111, 7'h7F, gap);
        end
    endtask

    task automatic do_reset();
        an    = 4'b1111;
        seg   = 7'h7F;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic check_model(input string tag);
        logic [15:0] exp_d;
        drive(4'b1111, 7'h7F, 5);
        exp_d = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        check_eq({tag, ".digits"}, 32'(digits), 32'(exp_d));
        check_eq({tag, ".min"}, 32'(min), 32'(m_bin(m_dig[3], m_dig[2])));
        check_eq({tag, ".sec"}, 32'(sec), 32'(m_bin(m_dig[1], m_dig[0])));
        check_eq({tag, ".err"}, 32'(err), 32'(m_err));
        check_eq({tag, ".upd_cnt"}, 32'(upd_seen), 32'(m_upd));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".digits"}, 32'(digits), 32'h0000_FFFF);
        check_eq({tag, ".min"}, 32'(min), 32'h7F);
        check_eq({tag, ".sec"}, 32'(sec), 32'h7F);
        check_eq({tag, ".upd"}, 32'(upd), 32'h0);
        check_eq({tag, ".err"}, 32'(err), 32'h0);
    endtask

    initial begin
        int base;
        logic [15:0] val;
        reset = 1'b1;
        an    = 4'b1111;
        seg   = 7'h7F;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("reset");

        // 05:39 with long dwell
        base = upd_seen;
        repeat (3) scan_frame(16'h0539, 100, 0, 1'b0);
        check_model("scan0539");
        check_eq("scan0539.value", 32'(digits), 32'h0539);
        check_eq("scan0539.one_upd", 32'(upd_seen - base), 32'd1);

        // Ghost pattern ahead of the seconds digit must not appear
        do_reset();
        repeat (3) scan_frame(16'h0539, 20, 0, 1'b1);
        check_model("ghost");
        check_eq("ghost.value", 32'(digits), 32'h0539);

        // Dwell one short of the settle window never captures
        do_reset();
        base = upd_seen;
        repeat (4) scan_frame(16'h0539, SETTLE - 1, 0, 1'b0);
        check_model("short");
        check_eq("short.value", 32'(digits), 32'h0000_FFFF);
        check_eq("short.no_upd", 32'(upd_seen - base), 32'd0);

        // Bus fault mid-scan, then clean frames
        scan_frame(16'h1200, 30, 0, 1'b0);
        drive(4'b0111, seg_of(1), 30);
        drive(4'b0011, 7'h24, 5);
        repeat (3) scan_frame(16'h1200, 30, 1, 1'b0);
        check_model("fault");
        check_eq("fault.err", 32'(err), 32'd1);
        check_eq("fault.value", 32'(digits), 32'h1200);

        // Illegal pattern on minute ones
        do_reset();
        repeat (3) scan_frame(16'h0E39, 25, 0, 1'b0);
        check_model("illegal");
        check_eq("illegal.min", 32'(min), 32'h7F);
        check_eq("illegal.sec", 32'(sec), 32'd39);

        // Display change, then reset in the middle of a frame
        do_reset();
        repeat (2) scan_frame(16'h0539, 20, 0, 1'b0);
        repeat (2) scan_frame(16'h0540, 20, 0, 1'b0);
        check_model("change");
        drive(4'b0111, seg_of(0), 20);
        drive(4'b1011, seg_of(5), 20);
        base = upd_seen;
        do_reset();
        repeat (4) @(negedge clk);
        check_reset_vals("midreset");
        check_eq("midreset.no_upd", 32'(upd_seen - base), 32'd0);
        repeat (2) scan_frame(16'h0540, 20, 0, 1'b0);
        check_model("republish");
        check_eq("republish.one_upd", 32'(upd_seen - base), 32'd1);

        // Randomized scans against the model
        for (int r = 0; r < 10; r++) begin
            if (r % 4 == 0) do_reset();
            val = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 11))
                    0:       val[k*4 +: 4] = 4'hF;
                    1:       val[k*4 +: 4] = 4'hE;
                    default: val[k*4 +: 4] = 4'($urandom_range(0, 9));
                endcase
            end
            for (int f = 0; f < 3; f++) begin
                scan_frame(val, 0, int'($urandom_range(0, 2)), 1'b0);
                if ($urandom_range(0, 7) == 0) drive(4'b0101, 7'h7F, int'($urandom_range(1, 5)));
            end
            check_model($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
